// File: rtl/thunderbolt_tsip_tx_pkg.sv
// Shared constants for the TSIP transmit framer: bus address map, framing bytes and FSM states.
package thunderbolt_tsip_tx_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 8;
    localparam int LEN_W      = 5;

    localparam logic [7:0] TSIP_DLE = 8'h10;
    localparam logic [7:0] TSIP_ETX = 8'h03;

    localparam logic [ADDR_WIDTH-1:0] TSIP_TX_ID       = 8'h00;
    localparam logic [ADDR_WIDTH-1:0] TSIP_TX_LEN      = 8'h01;
    localparam logic [ADDR_WIDTH-1:0] TSIP_TX_CTRL     = 8'h02;
    localparam logic [ADDR_WIDTH-1:0] TSIP_TX_BUF_BASE = 8'h10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SOH,
        ST_ID,
        ST_STUFF_ID,
        ST_DATA,
        ST_STUFF,
        ST_EOP_DLE,
        ST_EOP_ETX,
        ST_DONE
    } tsip_tx_state_e;

    function automatic logic [DATA_WIDTH-1:0] tsip_status(input logic err_busy, input logic err_len,
                                                          input logic done, input logic busy);
        return {4'b0000, err_busy, err_len, done, busy};
    endfunction

endpackage

// File: rtl/thunderbolt_tsip_tx_framer.sv
// TSIP frame sequencer: emits DLE, ID, DLE-stuffed payload, DLE ETX with a valid/ready handshake.
module thunderbolt_tsip_tx_framer
    import thunderbolt_tsip_tx_pkg::*;
#(
    parameter int         MAX_PAYLOAD = 16,
    parameter logic [7:0] DLE         = TSIP_DLE,
    parameter logic [7:0] ETX         = TSIP_ETX,
    localparam int        IDX_W       = $clog2(MAX_PAYLOAD) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [7:0]       i_id,
    input  logic [IDX_W-1:0] i_len,
    input  logic [7:0]       i_pay_byte,
    output logic [IDX_W-2:0] o_pay_idx,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_dv,
    input  logic             i_tx_ready,
    output logic             o_busy,
    output logic             o_idle,
    output logic             o_done
);

    tsip_tx_state_e   state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        o_tx_dv   = 1'b0;
        o_tx_data = 8'h00;
        o_done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_SOH;
                    idx_d   = '0;
                end
            end
            ST_SOH: begin
                o_tx_dv   = 1'b1;
                o_tx_data = DLE;
                if (i_tx_ready) state_d = ST_ID;
            end
            ST_ID: begin
                o_tx_dv   = 1'b1;
                o_tx_data = i_id;
                if (i_tx_ready) begin
                    if (i_id == DLE)      state_d = ST_STUFF_ID;
                    else if (i_len == '0) state_d = ST_EOP_DLE;
                    else                  state_d = ST_DATA;
                end
            end
            ST_STUFF_ID: begin
                o_tx_dv   = 1'b1;
                o_tx_data = DLE;
                if (i_tx_ready) state_d = (i_len == '0) ? ST_EOP_DLE : ST_DATA;
            end
            ST_DATA: begin
                o_tx_dv   = 1'b1;
                o_tx_data = i_pay_byte;
                if (i_tx_ready) begin
                    if (i_pay_byte == DLE) begin
                        state_d = ST_STUFF;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        if (idx_d == i_len) state_d = ST_EOP_DLE;
                    end
                end
            end
            // The escape DLE repeats the payload byte's slot; idx only moves once it is out.
            ST_STUFF: begin
                o_tx_dv   = 1'b1;
                o_tx_data = DLE;
                if (i_tx_ready) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = (idx_d == i_len) ? ST_EOP_DLE : ST_DATA;
                end
            end
            ST_EOP_DLE: begin
                o_tx_dv   = 1'b1;
                o_tx_data = DLE;
                if (i_tx_ready) state_d = ST_EOP_ETX;
            end
            ST_EOP_ETX: begin
                o_tx_dv   = 1'b1;
                o_tx_data = ETX;
                if (i_tx_ready) state_d = ST_DONE;
            end
            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_pay_idx = idx_q[IDX_W-2:0];
    assign o_idle    = (state_q == ST_IDLE);
    assign o_busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: rtl/thunderbolt_tsip_tx.sv
// TSIP transmit block: host register file (ID, LEN, CTRL/status, payload buffer) around the framer.
module thunderbolt_tsip_tx
    import thunderbolt_tsip_tx_pkg::*;
#(
    parameter int         MAX_PAYLOAD = 16,
    parameter logic [7:0] DLE         = TSIP_DLE,
    parameter logic [7:0] ETX         = TSIP_ETX
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_dv,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int                    IDX_W    = $clog2(MAX_PAYLOAD) + 1;
    localparam logic [ADDR_WIDTH-1:0] BUF_MASK = ADDR_WIDTH'(~(MAX_PAYLOAD - 1));

    logic [7:0]            id_q, id_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [7:0]            pay_q [MAX_PAYLOAD];
    logic [7:0]            pay_d [MAX_PAYLOAD];
    logic                  done_q, done_d;
    logic                  err_len_q, err_len_d;
    logic                  err_busy_q, err_busy_d;
    logic [DATA_WIDTH-1:0] o_data_q, o_data_d;

    logic             start;
    logic             ctrl_wr;
    logic             buf_hit;
    logic             fr_busy;
    logic             fr_idle;
    logic             fr_done;
    logic [IDX_W-2:0] fr_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            id_q       <= '0;
            len_q      <= '0;
            pay_q      <= '{default: '0};
            done_q     <= 1'b0;
            err_len_q  <= 1'b0;
            err_busy_q <= 1'b0;
            o_data_q   <= '0;
        end else begin
            id_q       <= id_d;
            len_q      <= len_d;
            pay_q      <= pay_d;
            done_q     <= done_d;
            err_len_q  <= err_len_d;
            err_busy_q <= err_busy_d;
            o_data_q   <= o_data_d;
        end
    end

    always_comb begin
        id_d       = id_q;
        len_d      = len_q;
        pay_d      = pay_q;
        done_d     = done_q;
        err_len_d  = err_len_q;
        err_busy_d = err_busy_q;
        o_data_d   = '0;
        start      = 1'b0;
        ctrl_wr    = i_wr && (i_addr == TSIP_TX_CTRL);
        buf_hit    = (i_addr & BUF_MASK) == TSIP_TX_BUF_BASE;

        // Frame contents are frozen while the framer is reading them.
        if (i_wr && !fr_busy) begin
            if (i_addr == TSIP_TX_ID)  id_d  = i_data;
            if (i_addr == TSIP_TX_LEN) len_d = i_data[LEN_W-1:0];
            if (buf_hit)               pay_d[i_addr[IDX_W-2:0]] = i_data;
        end

        // Clear runs before GO so a combined write can re-flag a fresh error.
        if (ctrl_wr && i_data[1]) begin
            err_len_d  = 1'b0;
            err_busy_d = 1'b0;
        end
        if (ctrl_wr && i_data[0]) begin
            if (!fr_idle) begin
                err_busy_d = 1'b1;
            end else if (int'(len_q) > MAX_PAYLOAD) begin
                err_len_d = 1'b1;
            end else begin
                start  = 1'b1;
                done_d = 1'b0;
            end
        end
        if (fr_done) done_d = 1'b1;

        if (i_addr == TSIP_TX_ID)        o_data_d = id_q;
        else if (i_addr == TSIP_TX_LEN)  o_data_d = {{(DATA_WIDTH-LEN_W){1'b0}}, len_q};
        else if (i_addr == TSIP_TX_CTRL) o_data_d = tsip_status(err_busy_q, err_len_q, done_q, fr_busy);
        else if (buf_hit)                o_data_d = pay_q[i_addr[IDX_W-2:0]];
    end

    thunderbolt_tsip_tx_framer #(
        .MAX_PAYLOAD (MAX_PAYLOAD),
        .DLE         (DLE),
        .ETX         (ETX)
    ) u_framer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (start),
        .i_id       (id_q),
        .i_len      (len_q[IDX_W-1:0]),
        .i_pay_byte (pay_q[fr_idx]),
        .o_pay_idx  (fr_idx),
        .o_tx_data  (o_tx_data),
        .o_tx_dv    (o_tx_dv),
        .i_tx_ready (i_tx_ready),
        .o_busy     (fr_busy),
        .o_idle     (fr_idle),
        .o_done     (fr_done)
    );

    assign o_data = o_data_q;
    assign o_busy = fr_busy;
    assign o_done = fr_done;

endmodule

// File: tb/tb_thunderbolt_tsip_tx.sv
// Randomized bench for the TSIP transmit framer against a queue-based frame model.
module tb_thunderbolt_tsip_tx;
    import thunderbolt_tsip_tx_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_wr;
    logic [7:0] i_addr;
    logic [7:0] i_data;
    logic [7:0] o_data;
    logic [7:0] o_tx_data;
    logic       o_tx_dv;
    logic       i_tx_ready;
    logic       o_busy;
    logic       o_done;

    always #5 i_clk = ~i_clk;

    thunderbolt_tsip_tx dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wr       (i_wr),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .o_data     (o_data),
        .o_tx_data  (o_tx_data),
        .o_tx_dv    (o_tx_dv),
        .i_tx_ready (i_tx_ready),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    bit         rand_mode = 1'b0;
    logic [7:0] got_q [$];
    int         cyc_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] pl [16];
    logic       m_done = 1'b0;
    logic       m_el = 1'b0;
    logic       m_eb = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] held_data = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // UART side: ready is either held high or randomly throttled.
    initial begin
        i_tx_ready = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            i_tx_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Byte monitor plus stall-stability check, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge i_clk);
            cyc++;
            if (o_done) done_cnt++;
            if (stall_prev && !i_rst) begin
                check_eq("stall_dv", 32'(o_tx_dv), 32'd1);
                check_eq("stall_data", 32'(o_tx_data), 32'(held_data));
            end
            if (o_tx_dv && i_tx_ready) begin
                got_q.push_back(o_tx_data);
                cyc_q.push_back(cyc);
            end
            stall_prev = o_tx_dv && !i_tx_ready;
            held_data  = o_tx_data;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        i_wr   = 1'b1;
        i_addr = a;
        i_data = d;
        @(posedge i_clk);
        #1;
        i_wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [7:0] d);
        i_addr = a;
        @(posedge i_clk);
        #1;
        d = o_data;
    endtask

    task automatic check_status(input string tag);
        logic [7:0] v;
        bus_rd(TSIP_TX_CTRL, v);
        check_eq(tag, 32'(v), 32'({4'b0000, m_eb, m_el, m_done, 1'b0}));
    endtask

    task automatic build_exp(input logic [7:0] id, input int len);
        exp_q.delete();
        exp_q.push_back(8'h10);
        exp_q.push_back(id);
        if (id == 8'h10) exp_q.push_back(8'h10);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(pl[i]);
            if (pl[i] == 8'h10) exp_q.push_back(8'h10);
        end
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h03);
    endtask

    task automatic load_regs(input logic [7:0] id, input int len);
        bus_wr(TSIP_TX_ID, id);
        bus_wr(TSIP_TX_LEN, 8'(len));
        for (int i = 0; i < len; i++) bus_wr(8'(TSIP_TX_BUF_BASE + i), pl[i]);
    endtask

    task automatic go_and_check_latency(input string tag);
        got_q.delete();
        cyc_q.delete();
        bus_wr(TSIP_TX_CTRL, 8'h01);
        m_done = 1'b0;
        check_eq({tag, "_lat_dv"}, 32'(o_tx_dv), 32'd1);
        check_eq({tag, "_lat_data"}, 32'(o_tx_data), 32'h10);
    endtask

    task automatic wait_done(input string tag, input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 500) begin
            idle(1);
            n++;
        end
        rand_mode = 1'b0;
        idle(3);
        check_eq({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        m_done = 1'b1;
    endtask

    task automatic compare_frame(input string tag, input bit back_to_back);
        check_eq({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        if (back_to_back && got_q.size() == exp_q.size() && got_q.size() > 0)
            check_eq({tag, "_span"}, 32'(cyc_q[cyc_q.size()-1] - cyc_q[0]), 32'(exp_q.size() - 1));
    endtask

    task automatic send_pkt(input string tag, input logic [7:0] id, input int len, input bit rnd);
        int d0;
        load_regs(id, len);
        build_exp(id, len);
        d0 = done_cnt;
        rand_mode = rnd;
        go_and_check_latency(tag);
        wait_done(tag, d0);
        compare_frame(tag, !rnd);
    endtask

    task automatic set_pl(input logic [7:0] b0, b1, b2, b3, b4);
        pl[0] = b0; pl[1] = b1; pl[2] = b2; pl[3] = b3; pl[4] = b4;
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] saved;
        int d0;
        int n;
        logic [7:0] rid;
        int rlen;

        i_rst  = 1'b1;
        i_wr   = 1'b0;
        i_addr = 8'h00;
        i_data = 8'h00;
        for (int i = 0; i < 16; i++) pl[i] = 8'h00;
        idle(3);
        i_rst = 1'b0;

        check_eq("rst_tx_dv", 32'(o_tx_dv), 32'd0);
        check_eq("rst_tx_data", 32'(o_tx_data), 32'd0);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_done", 32'(o_done), 32'd0);
        check_eq("rst_o_data", 32'(o_data), 32'd0);
        bus_rd(TSIP_TX_ID, v);             check_eq("rst_id", 32'(v), 32'd0);
        bus_rd(TSIP_TX_LEN, v);            check_eq("rst_len", 32'(v), 32'd0);
        bus_rd(8'(TSIP_TX_BUF_BASE + 7), v); check_eq("rst_buf7", 32'(v), 32'd0);
        bus_rd(8'h0B, v);                  check_eq("unmapped", 32'(v), 32'd0);
        check_status("rst_status");

        // Oversized length is rejected outright.
        got_q.delete();
        bus_wr(TSIP_TX_LEN, 8'd17);
        bus_wr(TSIP_TX_CTRL, 8'h01);
        m_el = 1'b1;
        idle(5);
        check_eq("len17_no_tx", 32'(got_q.size()), 32'd0);
        check_status("len17_status");
        bus_wr(TSIP_TX_CTRL, 8'h02);
        m_el = 1'b0;
        check_status("clr_err_status");

        // CLR_ERR together with GO: clear first, then GO re-flags err_len.
        bus_wr(TSIP_TX_CTRL, 8'h03);
        m_el = 1'b1;
        idle(3);
        check_eq("clrgo_no_tx", 32'(got_q.size()), 32'd0);
        check_status("clrgo_status");
        bus_wr(TSIP_TX_CTRL, 8'h02);
        m_el = 1'b0;

        set_pl(8'hA5, 8'h00, 8'h45, 8'h00, 8'h00);
        send_pkt("pkt1", 8'h8E, 5, 1'b0);
        check_status("pkt1_status");

        set_pl(8'h10, 8'h03, 8'h00, 8'h00, 8'h00);
        send_pkt("pkt_dle", 8'h8E, 2, 1'b0);

        send_pkt("pkt_len0", 8'h21, 0, 1'b0);

        set_pl(8'hA5, 8'h00, 8'h45, 8'h00, 8'h00);
        send_pkt("pkt1_stall", 8'h8E, 5, 1'b1);

        send_pkt("pkt_id_dle", 8'h10, 0, 1'b0);

        // GO and register writes while a packet is on the wire.
        for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
        pl[2] = 8'h5A;
        load_regs(8'h47, 16);
        build_exp(8'h47, 16);
        d0 = done_cnt;
        go_and_check_latency("busy");
        idle(1);
        check_eq("busy_flag", 32'(o_busy), 32'd1);
        bus_wr(TSIP_TX_CTRL, 8'h01);
        m_eb = 1'b1;
        saved = pl[2];
        bus_wr(8'(TSIP_TX_BUF_BASE + 2), ~saved);
        bus_wr(TSIP_TX_LEN, 8'd3);
        bus_wr(TSIP_TX_ID, 8'h99);
        wait_done("busy", d0);
        compare_frame("busy", 1'b0);
        bus_rd(8'(TSIP_TX_BUF_BASE + 2), v); check_eq("busy_buf_kept", 32'(v), 32'(saved));
        bus_rd(TSIP_TX_LEN, v);              check_eq("busy_len_kept", 32'(v), 32'd16);
        bus_rd(TSIP_TX_ID, v);               check_eq("busy_id_kept", 32'(v), 32'h47);
        check_status("busy_status");
        bus_wr(TSIP_TX_CTRL, 8'h02);
        m_eb = 1'b0;
        check_status("busy_clr_status");

        for (int k = 0; k < 8; k++) begin
            rid  = ($urandom_range(0, 3) == 0) ? 8'h10 : 8'($urandom);
            rlen = int'($urandom_range(0, 16));
            for (int i = 0; i < 16; i++) begin
                case ($urandom_range(0, 3))
                    0:       pl[i] = 8'h10;
                    1:       pl[i] = 8'h03;
                    default: pl[i] = 8'($urandom);
                endcase
            end
            send_pkt($sformatf("rnd%0d", k), rid, rlen, k[0]);
        end

        // Reset in the middle of a frame.
        set_pl(8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
        load_regs(8'h6C, 5);
        got_q.delete();
        bus_wr(TSIP_TX_CTRL, 8'h01);
        n = 0;
        while (got_q.size() < 3 && n < 50) begin
            idle(1);
            n++;
        end
        check_eq("midrst_reached3", 32'(got_q.size() >= 3), 32'd1);
        i_rst = 1'b1;
        idle(1);
        i_rst = 1'b0;
        m_done = 1'b0; m_el = 1'b0; m_eb = 1'b0;
        check_eq("midrst_dv", 32'(o_tx_dv), 32'd0);
        check_eq("midrst_busy", 32'(o_busy), 32'd0);
        d0 = done_cnt;
        got_q.delete();
        bus_rd(TSIP_TX_ID, v);             check_eq("midrst_id", 32'(v), 32'd0);
        bus_rd(TSIP_TX_LEN, v);            check_eq("midrst_len", 32'(v), 32'd0);
        bus_rd(8'(TSIP_TX_BUF_BASE + 1), v); check_eq("midrst_buf1", 32'(v), 32'd0);
        check_status("midrst_status");
        idle(10);
        check_eq("midrst_no_bytes", 32'(got_q.size()), 32'd0);
        check_eq("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        send_pkt("post_rst", 8'h6C, 5, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
